// File: rtl/core_pkg.sv
// Shared constants and fetch FSM encoding for the core front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package core_pkg;

  localparam logic [31:0] PC_INIT  = 32'h0000_0008;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0

  // IDLE: post-reset settle cycle; REQ: request on the bus; WAIT: granted,
  // awaiting response; HOLD: buffer full, waiting for decode; DRAIN: a
  // redirected fetch is still outstanding and its response must be dropped.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/fetch_issue_if.sv
// Bundles the instruction-memory handshake and the fetch-to-decode signals.
// Latency: n/a (wires only).
// Backpressure: imem_gnt throttles requests; dec_stall holds the fetch buffer.
interface fetch_issue_if #(
  parameter int unsigned W = 32
);

  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [W-1:0] imem_rdata;

  logic         dec_stall;
  logic         redirect;
  logic [W-1:0] redirect_pc;

  logic         fe_en;
  logic [W-1:0] fe_pc;
  logic [W-1:0] fe_next_pc;
  logic [W-1:0] fe_inst;

  // Fetch unit side.
  modport master (
    output imem_req, imem_addr, fe_en, fe_pc, fe_next_pc, fe_inst,
    input  imem_gnt, imem_rvalid, imem_rdata, dec_stall, redirect, redirect_pc
  );

  // Memory + decode side.
  modport slave (
    input  imem_req, imem_addr, fe_en, fe_pc, fe_next_pc, fe_inst,
    output imem_gnt, imem_rvalid, imem_rdata, dec_stall, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_buf.sv
// One-entry holding buffer for a fetched instruction and its PC.
// Latency: load visible the cycle after the load strobe.
// Backpressure: entry stays valid until consume or flush; flush beats load.
module fetch_buf #(
  parameter int unsigned    W        = 32,
  parameter logic [W-1:0]   PC_INIT  = W'(core_pkg::PC_INIT),
  parameter logic [W-1:0]   NOP_INST = W'(core_pkg::NOP_INST)
) (
  input  logic         clk,
  input  logic         a_reset,
  input  logic         load,
  input  logic [W-1:0] load_inst,
  input  logic [W-1:0] load_pc,
  input  logic         consume,
  input  logic         flush,
  output logic         buf_valid,
  output logic [W-1:0] buf_inst,
  output logic [W-1:0] buf_pc
);

  // Valid flag: flush wins, then load, then consume.
  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      buf_valid <= 1'b0;
    end else if (flush) begin
      buf_valid <= 1'b0;
    end else if (load) begin
      buf_valid <= 1'b1;
    end else if (consume) begin
      buf_valid <= 1'b0;
    end
  end

  // Payload only changes on an accepted load; a flush leaves the old PC visible.
  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      buf_inst <= NOP_INST;
      buf_pc   <= PC_INIT;
    end else if (load && !flush) begin
      buf_inst <= load_inst;
      buf_pc   <= load_pc;
    end
  end

endmodule

// File: rtl/fetch_issue.sv
// Fetch front end: sequential PC, single-outstanding imem req/gnt/rvalid, one-entry buffer, NOP bubbles, redirect flush.
// Latency: rvalid in cycle N -> fe_inst in N+1 -> next imem_req in N+2 (one instruction per 3 cycles + memory latency).
// Backpressure: dec_stall holds buffer and HOLD state with fe_en low; optional FETCH_PERF_CNT_EN adds perf counters.
module fetch_issue #(
  parameter int unsigned  W        = 32,
  parameter logic [W-1:0] PC_INIT  = W'(core_pkg::PC_INIT),
  parameter logic [W-1:0] NOP_INST = W'(core_pkg::NOP_INST)
) (
  input  logic           clk,
  input  logic           a_reset,
  fetch_issue_if.master  bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]    perf_fetch_cnt,
  output logic [31:0]    perf_bubble_cnt
`endif
);

  import core_pkg::*;

  fetch_state_t state_q, state_d;
  logic [W-1:0] pc_q, pc_d;

  logic         buf_valid;
  logic [W-1:0] buf_inst;
  logic [W-1:0] buf_pc;
  logic         buf_load;
  logic         buf_consume;
  logic         buf_flush;

  logic         fe_en;
  logic         redir_act;
  logic         outstanding;

  // Fetch targets are word aligned, so the low redirect bits are dropped.
  logic         unused_redir_lsb;
  assign unused_redir_lsb = ^bus.redirect_pc[1:0];

  assign fe_en     = !bus.dec_stall && (state_q != IDLE);
  assign redir_act = bus.redirect && (state_q != IDLE);

  // A granted fetch whose response has not yet come back must be drained.
  assign outstanding = (((state_q == WAIT) || (state_q == DRAIN)) && !bus.imem_rvalid)
                     || ((state_q == REQ) && bus.imem_gnt);

  // State and PC registers.
  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      state_q <= IDLE;
      pc_q    <= PC_INIT;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state, next PC and buffer strobes; redirect overrides everything past IDLE.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_load    = 1'b0;
    buf_consume = 1'b0;
    buf_flush   = 1'b0;
    if (redir_act) begin
      pc_d      = {bus.redirect_pc[W-1:2], 2'b00};
      buf_flush = 1'b1;
      state_d   = outstanding ? DRAIN : REQ;
    end else begin
      case (state_q)
        IDLE:  state_d = REQ;
        REQ:   if (bus.imem_gnt) state_d = WAIT;
        WAIT: begin
          if (bus.imem_rvalid) begin
            buf_load = 1'b1;
            pc_d     = pc_q + W'(4);
            state_d  = HOLD;
          end
        end
        HOLD: begin
          if (fe_en && buf_valid) begin
            buf_consume = 1'b1;
            state_d     = REQ;
          end
        end
        DRAIN: if (bus.imem_rvalid) state_d = REQ;
        default: state_d = IDLE;
      endcase
    end
  end

  fetch_buf #(
    .W        (W),
    .PC_INIT  (PC_INIT),
    .NOP_INST (NOP_INST)
  ) u_buf (
    .clk       (clk),
    .a_reset   (a_reset),
    .load      (buf_load),
    .load_inst (bus.imem_rdata),
    .load_pc   (pc_q),
    .consume   (buf_consume),
    .flush     (buf_flush),
    .buf_valid (buf_valid),
    .buf_inst  (buf_inst),
    .buf_pc    (buf_pc)
  );

  assign bus.imem_req   = (state_q == REQ);
  assign bus.imem_addr  = pc_q;
  assign bus.fe_en      = fe_en;
  assign bus.fe_inst    = (buf_valid && !bus.redirect) ? buf_inst : NOP_INST;
  assign bus.fe_pc      = buf_pc;
  assign bus.fe_next_pc = buf_pc + W'(4);

`ifdef FETCH_PERF_CNT_EN
  // Count captured fetches and bubbles (empty buffer or redirect squash) fed to decode.
  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      perf_fetch_cnt  <= 32'd0;
      perf_bubble_cnt <= 32'd0;
    end else begin
      if (buf_load) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (fe_en && (!buf_valid || bus.redirect)) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_issue.sv
// Directed bench for fetch_issue with a request/delivery scoreboard.
// Latency: n/a.
// Backpressure: bench plays memory (gnt/rvalid) and decode (dec_stall/redirect).
module tb_fetch_issue;

  import core_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } fe_exp_t;

  logic clk;
  logic a_reset;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] exp_addr[$];
  fe_exp_t     exp_fe[$];

  fetch_issue_if #(.W(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  fetch_issue #(
    .W        (32),
    .PC_INIT  (32'h0000_0008),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk     (clk),
    .a_reset (a_reset),
    .bus     (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!bus.imem_req && n < 20) begin
      cycle();
      n++;
    end
    if (!bus.imem_req) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_req: imem_req still %b after %0d cycles, expected 1", bus.imem_req, n);
    end
  endtask

  // One full fetch: optional grant delay, zero-wait response, optional stall on delivery.
  task automatic serve(input logic [31:0] addr, input logic [31:0] data,
                       input int gnt_wait, input bit stall);
    fe_exp_t e;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] b0;
`endif
    wait_req();
    e.pc   = addr;
    e.inst = data;
    exp_addr.push_back(addr);
    exp_fe.push_back(e);
`ifdef FETCH_PERF_CNT_EN
    b0 = perf_bubble_cnt;
`endif
    for (int k = 0; k < gnt_wait; k++) begin
      chk("gnt_wait_req", 32'(bus.imem_req), 32'd1);
      chk("gnt_wait_addr", bus.imem_addr, addr);
      chk("gnt_wait_nop", bus.fe_inst, NOP);
      chk("gnt_wait_fe_en", 32'(bus.fe_en), 32'd1);
      cycle();
    end
`ifdef FETCH_PERF_CNT_EN
    if (gnt_wait > 0) chk("perf_bubbles", perf_bubble_cnt, b0 + 32'(gnt_wait));
`endif
    bus.imem_gnt = 1'b1;
    cycle();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = data;
    if (stall) bus.dec_stall = 1'b1;
    cycle();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
  endtask

  // Scoreboard monitor: accepted requests and delivered instructions are popped and compared.
  always @(negedge clk) begin
    fe_exp_t e;
    if (!a_reset) begin
      if (bus.imem_req && bus.imem_gnt) begin
        if (exp_addr.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_req: addr %h, expected no request", bus.imem_addr);
        end else begin
          chk("req_addr", bus.imem_addr, exp_addr.pop_front());
        end
      end
      if (bus.fe_en && bus.fe_inst != NOP) begin
        if (exp_fe.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_inst: inst %h pc %h, expected NOP", bus.fe_inst, bus.fe_pc);
        end else begin
          e = exp_fe.pop_front();
          chk("fe_inst", bus.fe_inst, e.inst);
          chk("fe_pc", bus.fe_pc, e.pc);
          chk("fe_next_pc", bus.fe_next_pc, e.pc + 32'd4);
        end
      end
      if (dut.state_q == DRAIN) chk("drain_nop", bus.fe_inst, NOP);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_reset         = 1'b1;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.dec_stall   = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;

    // Reset values.
    cycle();
    cycle();
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h8);
    chk("rst_fe_en", 32'(bus.fe_en), 32'd0);
    chk("rst_fe_pc", bus.fe_pc, 32'h8);
    chk("rst_fe_next_pc", bus.fe_next_pc, 32'hC);
    chk("rst_fe_inst", bus.fe_inst, NOP);
    a_reset = 1'b0;
    chk("idle_fe_en", 32'(bus.fe_en), 32'd0);
    cycle();

    // Zero-wait fetch of 0x8, then next request at 0xC.
    chk("first_req", 32'(bus.imem_req), 32'd1);
    chk("first_addr", bus.imem_addr, 32'h8);
    serve(32'h8, 32'h0000_0093, 0, 1'b0);
    cycle();
    chk("next_req", 32'(bus.imem_req), 32'd1);
    chk("next_addr", bus.imem_addr, 32'hC);

    // Response held by a 4-cycle stall.
    serve(32'hC, 32'h0000_0113, 0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("stall_fe_en", 32'(bus.fe_en), 32'd0);
      chk("stall_inst", bus.fe_inst, 32'h0000_0113);
      chk("stall_pc", bus.fe_pc, 32'hC);
      chk("stall_no_req", 32'(bus.imem_req), 32'd0);
      cycle();
    end
    bus.dec_stall = 1'b0;
    cycle();
    chk("post_stall_req", 32'(bus.imem_req), 32'd1);
    chk("post_stall_addr", bus.imem_addr, 32'h10);

    // Redirect together with grant of 0x10: drain, then fetch 0x100.
    exp_addr.push_back(32'h10);
    bus.imem_gnt    = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h103;
    chk("redir_gnt_nop", bus.fe_inst, NOP);
    cycle();
    bus.imem_gnt = 1'b0;
    bus.redirect = 1'b0;
    chk("drain_no_req", 32'(bus.imem_req), 32'd0);
    cycle();
    chk("drain_no_req2", 32'(bus.imem_req), 32'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBAD0_0093;
    cycle();
    bus.imem_rvalid = 1'b0;
    chk("post_drain_req", 32'(bus.imem_req), 32'd1);
    chk("post_drain_addr", bus.imem_addr, 32'h100);
    serve(32'h100, 32'h0000_0193, 0, 1'b0);

    // Redirect coinciding with rvalid of 0x104: data dropped.
    wait_req();
    exp_addr.push_back(32'h104);
    bus.imem_gnt = 1'b1;
    cycle();
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0000_0213;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    chk("redir_rv_nop", bus.fe_inst, NOP);
    cycle();
    bus.imem_rvalid = 1'b0;
    bus.redirect    = 1'b0;
    chk("redir_rv_req", 32'(bus.imem_req), 32'd1);
    chk("redir_rv_addr", bus.imem_addr, 32'h200);
    chk("redir_rv_nop2", bus.fe_inst, NOP);
    serve(32'h200, 32'h0000_0293, 0, 1'b0);

    // Grant withheld for 5 cycles.
    serve(32'h204, 32'h0000_0313, 5, 1'b0);

    // Reset pulse while in WAIT, then a late response.
    wait_req();
    exp_addr.push_back(32'h208);
    bus.imem_gnt = 1'b1;
    cycle();
    bus.imem_gnt = 1'b0;
    cycle();
    a_reset = 1'b1;
    #1;
    chk("mid_rst_req", 32'(bus.imem_req), 32'd0);
    chk("mid_rst_addr", bus.imem_addr, 32'h8);
    chk("mid_rst_fe_en", 32'(bus.fe_en), 32'd0);
    chk("mid_rst_fe_pc", bus.fe_pc, 32'h8);
    chk("mid_rst_fe_next_pc", bus.fe_next_pc, 32'hC);
    chk("mid_rst_fe_inst", bus.fe_inst, NOP);
    cycle();
    a_reset         = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_0093;
    chk("late_rsp_fe_en", 32'(bus.fe_en), 32'd0);
    cycle();
    bus.imem_rvalid = 1'b0;
    chk("restart_req", 32'(bus.imem_req), 32'd1);
    chk("restart_addr", bus.imem_addr, 32'h8);
    chk("restart_nop", bus.fe_inst, NOP);
    serve(32'h8, 32'h0000_0393, 0, 1'b0);
    cycle();
    cycle();

`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, 32'd1);
`endif
    chk("addr_queue_empty", 32'(exp_addr.size()), 32'd0);
    chk("fe_queue_empty", 32'(exp_fe.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
